// File: rtl/vq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vq_pkg : constants shared by the vector quantizer and dequantizer     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package vq_pkg;
    localparam int VQ_SCALE   = 2408;
    localparam int VQ_RECIP   = 6967;
    localparam int VQ_FRAC    = 24;
    localparam int VQ_VEC_LEN = 8;
    localparam int VQ_QMIN    = -128;
    localparam int VQ_QMAX    = 127;
    localparam int VQ_PROD_W  = 48;
    localparam int VQ_CODE_W  = 8;

    typedef logic signed [VQ_CODE_W-1:0] vq_code_t;
endpackage
`default_nettype wire

// File: rtl/vq_round_sat.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vq_round_sat : round-half-up shift and 8-bit saturation, with flag    |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module vq_round_sat
    import vq_pkg::*;
#(
    parameter int IN_W = VQ_PROD_W,
    parameter int FRAC = VQ_FRAC
) (
    input  logic signed [IN_W-1:0] i_prod,
    output vq_code_t               o_code,
    output logic                   o_sat
);
    localparam logic signed [IN_W:0] c_half =
        {{(IN_W-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [IN_W:0] c_qmax = (IN_W+1)'(VQ_QMAX);
    localparam logic signed [IN_W:0] c_qmin = (IN_W+1)'(VQ_QMIN);

    logic signed [IN_W:0] w_sum;
    logic signed [IN_W:0] w_shift;

    // One guard bit keeps the rounding add from overflowing for any input
    assign w_sum   = {i_prod[IN_W-1], i_prod} + c_half;
    assign w_shift = w_sum >>> FRAC;

    always_comb begin
        o_sat  = 1'b0;
        o_code = w_shift[VQ_CODE_W-1:0];
        if (w_shift > c_qmax) begin
            o_sat  = 1'b1;
            o_code = vq_code_t'(VQ_QMAX);
        end else if (w_shift < c_qmin) begin
            o_sat  = 1'b1;
            o_code = vq_code_t'(VQ_QMIN);
        end
    end
endmodule
`default_nettype wire

// File: rtl/quantize_vec8.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | quantize_vec8 : int32 -> int8 vector quantizer, 2-cycle pipeline      |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module quantize_vec8
    import vq_pkg::*;
#(
    parameter int VEC_LEN = VQ_VEC_LEN,
    parameter int RECIP   = VQ_RECIP,
    parameter int FRAC    = VQ_FRAC
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic signed [31:0] din_i,
    input  logic               valid_i,
    output logic               valid_o,
    output logic signed [7:0]  dout_o,
    output logic [2:0]         idx_o,
    output logic               done_o,
    output logic [3:0]         sat_cnt_o
);
    logic signed [VQ_PROD_W-1:0] w_din_ext;
    logic signed [VQ_PROD_W-1:0] w_recip;
    logic signed [VQ_PROD_W-1:0] w_prod;
    vq_code_t                    w_code;
    logic                        w_sat;
    logic                        w_last;

    logic signed [VQ_PROD_W-1:0] r_p1;
    logic                        r_v1;
    logic                        r_valid;
    vq_code_t                    r_dout;
    logic [2:0]                  r_idx;
    logic                        r_done;
    logic [3:0]                  r_sat_cnt;
    logic [2:0]                  r_ecnt;
    logic [3:0]                  r_sacc;

    assign w_din_ext = VQ_PROD_W'(din_i);
    assign w_recip   = VQ_PROD_W'(RECIP);
    assign w_prod    = w_din_ext * w_recip;
    assign w_last    = (r_ecnt == 3'(VEC_LEN-1));

    vq_round_sat #(
        .IN_W (VQ_PROD_W),
        .FRAC (FRAC)
    ) u_round_sat (
        .i_prod (r_p1),
        .o_code (w_code),
        .o_sat  (w_sat)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_p1 <= '0;
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= valid_i;
            if (valid_i) begin
                r_p1 <= w_prod;
            end
        end
    end

    // Counter, accumulator and output registers only move on stage-2 valid cycles
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_valid   <= 1'b0;
            r_dout    <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_sat_cnt <= '0;
            r_ecnt    <= '0;
            r_sacc    <= '0;
        end else begin
            r_valid <= r_v1;
            r_done  <= r_v1 && w_last;
            if (r_v1) begin
                r_dout <= w_code;
                r_idx  <= r_ecnt;
                if (w_last) begin
                    r_ecnt    <= '0;
                    r_sat_cnt <= r_sacc + {3'b000, w_sat};
                    r_sacc    <= '0;
                end else begin
                    r_ecnt <= r_ecnt + 3'd1;
                    r_sacc <= r_sacc + {3'b000, w_sat};
                end
            end
        end
    end

    assign valid_o   = r_valid;
    assign dout_o    = r_dout;
    assign idx_o     = r_idx;
    assign done_o    = r_done;
    assign sat_cnt_o = r_sat_cnt;
endmodule
`default_nettype wire

// File: tb/tb_quantize_vec8.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_quantize_vec8 : directed self-checking bench for quantize_vec8     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_quantize_vec8;
    logic               clk_i;
    logic               rstn_i;
    logic signed [31:0] din_i;
    logic               valid_i;
    logic               valid_o;
    logic signed [7:0]  dout_o;
    logic [2:0]         idx_o;
    logic               done_o;
    logic [3:0]         sat_cnt_o;

    int                n_checks  = 0;
    int                n_errors  = 0;
    int                exp_idx   = 0;
    logic signed [7:0] last_code = 8'sd0;

    quantize_vec8 dut (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .din_i     (din_i),
        .valid_i   (valid_i),
        .valid_o   (valid_o),
        .dout_o    (dout_o),
        .idx_o     (idx_o),
        .done_o    (done_o),
        .sat_cnt_o (sat_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Inputs change on the falling edge; outputs are sampled there too
    task automatic drive(input logic v, input logic signed [31:0] d);
        valid_i = v;
        din_i   = d;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        n_checks++;
        if (valid_o !== 1'b0 || dout_o !== 8'sd0 || idx_o !== 3'd0 || done_o !== 1'b0 || sat_cnt_o !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_state: got v=%b q=%0d idx=%0d done=%b sat=%0d, want all 0",
                     valid_o, dout_o, idx_o, done_o, sat_cnt_o);
        end
        rstn_i = 1'b1;
    endtask

    task automatic test_basic();
        logic cv[$]; logic signed [31:0] cd[$]; logic signed [7:0] ce[$];
        for (int i = 0; i < 8; i++) begin cv.push_back(1'b1); cd.push_back(12040); ce.push_back(8'sd5); end
        for (int t = 0; t < cv.size() + 2; t++) begin
            if (t >= 2) begin
                n_checks++;
                if (cv[t-2]) begin
                    if (valid_o !== 1'b1 || dout_o !== ce[t-2] || idx_o !== 3'(exp_idx) || done_o !== (exp_idx == 7)) begin
                        n_errors++;
                        $display("FAIL basic_out e=%0d: got v=%b q=%0d idx=%0d done=%b, want v=1 q=%0d idx=%0d done=%b",
                                 t-2, valid_o, dout_o, idx_o, done_o, ce[t-2], exp_idx, exp_idx == 7);
                    end
                    if (exp_idx == 7) begin
                        n_checks++;
                        if (sat_cnt_o !== 4'd0) begin
                            n_errors++;
                            $display("FAIL basic_sat: got %0d, want 0", sat_cnt_o);
                        end
                    end
                    last_code = ce[t-2];
                    exp_idx   = (exp_idx + 1) % 8;
                end else if (valid_o !== 1'b0 || done_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL basic_idle: got v=%b done=%b, want 0 0", valid_o, done_o);
                end
            end
            if (t < cv.size()) drive(cv[t], cd[t]); else drive(1'b0, 0);
        end
    endtask

    task automatic test_rounding();
        logic signed [31:0] d[8] = '{-12040, 1204, 0, 2408, -2408, 12040, -1204, 7224};
        logic signed [7:0]  e[8] = '{-8'sd5, 8'sd0, 8'sd0, 8'sd1, -8'sd1, 8'sd5, 8'sd0, 8'sd3};
        for (int t = 0; t < 10; t++) begin
            if (t >= 2) begin
                n_checks++;
                if (valid_o !== 1'b1 || dout_o !== e[t-2] || idx_o !== 3'(exp_idx) || done_o !== (exp_idx == 7)) begin
                    n_errors++;
                    $display("FAIL round_out din=%0d: got v=%b q=%0d idx=%0d done=%b, want v=1 q=%0d idx=%0d done=%b",
                             d[t-2], valid_o, dout_o, idx_o, done_o, e[t-2], exp_idx, exp_idx == 7);
                end
                if (exp_idx == 7) begin
                    n_checks++;
                    if (sat_cnt_o !== 4'd0) begin
                        n_errors++;
                        $display("FAIL round_sat: got %0d, want 0", sat_cnt_o);
                    end
                end
                last_code = e[t-2];
                exp_idx   = (exp_idx + 1) % 8;
            end
            if (t < 8) drive(1'b1, d[t]); else drive(1'b0, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] cd[$]; logic signed [7:0] ce[$]; int es[$];
        for (int i = 0; i < 8; i++) begin cd.push_back(481600); ce.push_back(8'sd127); end
        for (int i = 0; i < 8; i++) begin cd.push_back(-4816); ce.push_back(-8'sd2); end
        es = '{8, 0};
        for (int t = 0; t < cd.size() + 2; t++) begin
            if (t >= 2) begin
                n_checks++;
                if (valid_o !== 1'b1 || dout_o !== ce[t-2] || idx_o !== 3'(exp_idx) || done_o !== (exp_idx == 7)) begin
                    n_errors++;
                    $display("FAIL b2b_out e=%0d: got v=%b q=%0d idx=%0d done=%b, want v=1 q=%0d idx=%0d done=%b",
                             t-2, valid_o, dout_o, idx_o, done_o, ce[t-2], exp_idx, exp_idx == 7);
                end
                if (exp_idx == 7) begin
                    n_checks++;
                    if (sat_cnt_o !== 4'(es[0])) begin
                        n_errors++;
                        $display("FAIL b2b_sat: got %0d, want %0d", sat_cnt_o, es[0]);
                    end
                    void'(es.pop_front());
                end
                last_code = ce[t-2];
                exp_idx   = (exp_idx + 1) % 8;
            end
            if (t < cd.size()) drive(1'b1, cd[t]); else drive(1'b0, 0);
        end
    endtask

    task automatic test_saturation();
        logic signed [31:0] d[8] = '{481600, 481600, 481600, -481600, -481600, 0, 0, 0};
        logic signed [7:0]  e[8] = '{8'sd127, 8'sd127, 8'sd127, -8'sd128, -8'sd128, 8'sd0, 8'sd0, 8'sd0};
        for (int t = 0; t < 10; t++) begin
            if (t >= 2) begin
                n_checks++;
                if (valid_o !== 1'b1 || dout_o !== e[t-2] || idx_o !== 3'(exp_idx) || done_o !== (exp_idx == 7)) begin
                    n_errors++;
                    $display("FAIL sat_out din=%0d: got v=%b q=%0d idx=%0d done=%b, want v=1 q=%0d idx=%0d done=%b",
                             d[t-2], valid_o, dout_o, idx_o, done_o, e[t-2], exp_idx, exp_idx == 7);
                end
                if (exp_idx == 7) begin
                    n_checks++;
                    if (sat_cnt_o !== 4'd5) begin
                        n_errors++;
                        $display("FAIL sat_cnt_done: got %0d, want 5", sat_cnt_o);
                    end
                end
                last_code = e[t-2];
                exp_idx   = (exp_idx + 1) % 8;
            end
            if (t < 8) drive(1'b1, d[t]); else drive(1'b0, 0);
        end
        repeat (3) drive(1'b0, 0);
        n_checks++;
        if (sat_cnt_o !== 4'd5 || done_o !== 1'b0 || dout_o !== last_code) begin
            n_errors++;
            $display("FAIL sat_hold: got sat=%0d done=%b q=%0d, want sat=5 done=0 q=%0d",
                     sat_cnt_o, done_o, dout_o, last_code);
        end
    endtask

    task automatic test_gapped();
        logic cv[$]; logic signed [31:0] cd[$]; logic signed [7:0] ce[$];
        for (int i = 0; i < 8; i++) begin
            cv.push_back(1'b1);
            cd.push_back(i == 7 ? 600000 : 2408 * i);
            ce.push_back(i == 7 ? 8'sd127 : 8'(i));
            if (i < 7) begin
                for (int g = 0; g < (i % 3) + 1; g++) begin
                    cv.push_back(1'b0); cd.push_back(32'sh7fff_ffff); ce.push_back(8'sd0);
                end
            end
        end
        for (int t = 0; t < cv.size() + 2; t++) begin
            if (t >= 2) begin
                n_checks++;
                if (cv[t-2]) begin
                    if (valid_o !== 1'b1 || dout_o !== ce[t-2] || idx_o !== 3'(exp_idx) || done_o !== (exp_idx == 7)) begin
                        n_errors++;
                        $display("FAIL gap_out c=%0d: got v=%b q=%0d idx=%0d done=%b, want v=1 q=%0d idx=%0d done=%b",
                                 t-2, valid_o, dout_o, idx_o, done_o, ce[t-2], exp_idx, exp_idx == 7);
                    end
                    if (exp_idx == 7) begin
                        n_checks++;
                        if (sat_cnt_o !== 4'd1) begin
                            n_errors++;
                            $display("FAIL gap_sat: got %0d, want 1", sat_cnt_o);
                        end
                    end
                    last_code = ce[t-2];
                    exp_idx   = (exp_idx + 1) % 8;
                end else if (valid_o !== 1'b0 || done_o !== 1'b0 || dout_o !== last_code || idx_o !== 3'(exp_idx + 7)) begin
                    n_errors++;
                    $display("FAIL gap_hold c=%0d: got v=%b done=%b q=%0d idx=%0d, want v=0 done=0 q=%0d idx=%0d",
                             t-2, valid_o, done_o, dout_o, idx_o, last_code, (exp_idx + 7) % 8);
                end
            end
            if (t < cv.size()) drive(cv[t], cd[t]); else drive(1'b0, 0);
        end
    endtask

    task automatic test_reset_mid();
        repeat (4) drive(1'b1, 12040);
        valid_i = 1'b1;
        #2 rstn_i = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 1'b0 || dout_o !== 8'sd0 || idx_o !== 3'd0 || done_o !== 1'b0 || sat_cnt_o !== 4'd0) begin
            n_errors++;
            $display("FAIL midreset_async: got v=%b q=%0d idx=%0d done=%b sat=%0d, want all 0",
                     valid_o, dout_o, idx_o, done_o, sat_cnt_o);
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        rstn_i  = 1'b1;
        exp_idx   = 0;
        last_code = 8'sd0;
        for (int t = 0; t < 10; t++) begin
            if (t >= 2) begin
                n_checks++;
                if (valid_o !== 1'b1 || dout_o !== -8'sd5 || idx_o !== 3'(exp_idx) || done_o !== (exp_idx == 7)) begin
                    n_errors++;
                    $display("FAIL midreset_out e=%0d: got v=%b q=%0d idx=%0d done=%b, want v=1 q=-5 idx=%0d done=%b",
                             t-2, valid_o, dout_o, idx_o, done_o, exp_idx, exp_idx == 7);
                end
                exp_idx = (exp_idx + 1) % 8;
            end else begin
                n_checks++;
                if (valid_o !== 1'b0 || done_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL midreset_flush t=%0d: got v=%b done=%b, want 0 0", t, valid_o, done_o);
                end
            end
            if (t < 8) drive(1'b1, -12040); else drive(1'b0, 0);
        end
        n_checks++;
        if (valid_o !== 1'b0 || done_o !== 1'b0 || sat_cnt_o !== 4'd0) begin
            n_errors++;
            $display("FAIL midreset_tail: got v=%b done=%b sat=%0d, want 0 0 0", valid_o, done_o, sat_cnt_o);
        end
    endtask

    initial begin
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        din_i   = 32'sd0;
        test_reset();
        test_basic();
        test_rounding();
        test_back_to_back();
        test_saturation();
        test_gapped();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/quantize_vec8.md
# quantize_vec8

Upstream stage of the vector-quantization datapath. Converts a stream of 32-bit signed activations into 8-bit signed codes using the fixed scale 2408 shared with the dequantizer: q = sat8(round(x / 2408)). It works on 8-element vectors and pipelines each element with 2-cycle latency. Its outputs (`dout_o`, `valid_o`, `done_o`) drive the dequantizer's `din_i`/`valid_i` directly and report per-vector saturation counts.

## Interface
Parameters:
- `VEC_LEN`, 8: elements per vector; power of two.
- `RECIP`, 6967: round(2^FRAC / 2408), the reciprocal scale.
- `FRAC`, 24: fractional bits of `RECIP`.

Ports:
- `clk_i`  in  1: clock; all state updates on the rising edge.
- `rstn_i`  in  1: asynchronous, active-low reset.
- `din_i`  in  32 signed: activation sample.
- `valid_i`  in  1: `din_i` is valid this cycle; no backpressure.
- `valid_o`  out  1: `dout_o` is valid.
- `dout_o`  out  8 signed: quantized code.
- `idx_o`  out  3: element index of `dout_o` within its vector (0..7).
- `done_o`  out  1: pulses with the last element of a vector.
- `sat_cnt_o`  out  4: count of saturated elements in the most recently completed vector (0..8).

## Operation
- Stage 1, on a `valid_i` cycle: p1 <= din_i * RECIP, a 48-bit signed product. Also register v1 <= valid_i.
- Stage 2, when v1 is high:
  - r = (p1 + 2^(FRAC-1)) >>> FRAC, an arithmetic shift (round half toward +inf).
  - r > 127 gives 127 with sat = 1; r < -128 gives -128 with sat = 1; otherwise r[7:0] with sat = 0.
  - Register the result into `dout_o`.
- Element counter `ecnt` (3 bits):
  - Advances only on stage-2 valid cycles and wraps 7 -> 0.
  - `idx_o` = `ecnt` value registered alongside `dout_o`.
- Vector boundary:
  - `done_o` = 1 in the cycle `valid_o` = 1 and `idx_o` = 7; 0 otherwise.
  - Running saturation count `sacc` (4 bits) adds sat on each stage-2 valid cycle.
  - On the last element: `sat_cnt_o` <= sacc + sat, and `sacc` <= 0.
- `sat_cnt_o` holds its value until the next vector completes.
- Gaps: `valid_i` may drop for any number of cycles mid-vector. Counters and `sacc` hold, and no partial-vector flush occurs.
- Back-to-back vectors with no idle cycle are supported; `idx_o` goes 7 -> 0 continuously.
- When `valid_o` = 0, `dout_o` and `idx_o` hold their last values.

## Timing
- Latency: `valid_i` at cycle N gives `valid_o` at N+2. Throughput is 1 element per cycle.
- Reset values: `valid_o` = 0, `dout_o` = 0, `idx_o` = 0, `done_o` = 0, `sat_cnt_o` = 0. Internal `ecnt`, `sacc`, p1 and v1 are also 0.
- Reset mid-vector discards in-flight data. The next accepted element is index 0.
- `done_o` is exactly one cycle wide per vector, unless the next vector's last element follows immediately (only possible when VEC_LEN = 1).
- There is no combinational path from inputs to outputs.

## Structure
- Shared package `vq_pkg` holds:
  - `VQ_SCALE` = 2408, used by both quantizer and dequantizer.
  - `VQ_RECIP` = 6967 and `VQ_FRAC` = 24.
  - `VQ_VEC_LEN` = 8.
  - `VQ_QMIN` = -128 and `VQ_QMAX` = 127.
- One sub-module, `vq_round_sat`: combinational rounding, shift and saturation from 48-bit to 8-bit, with a sat flag output. It is reusable by other requantization stages.
- The top level holds the pipeline registers, counter and accumulator.

## Test plan
- Reset, then 8 consecutive `valid_i` with din = 12040 (5*2408) -> `dout_o` = 5 ×8 starting 2 cycles later. `idx_o` goes 0..7, `done_o` is high only at `idx_o` = 7, and `sat_cnt_o` = 0.
- Signed and rounding values: din = -12040 -> -5; din = 1204 -> 0; din = 0 -> 0; din = 2408 -> 1; din = -2408 -> -1.
- Saturation: a vector with din = 481600 ×3, -481600 ×2 and 0 ×3 -> codes 127, -128 and 0. `sat_cnt_o` = 5 on the `done_o` cycle and held afterwards.
- Gapped input: 8 elements with 1-3 idle cycles between them -> outputs keep 2-cycle latency and contiguous `idx_o`, with a single `done_o`.
- Back-to-back: 16 consecutive elements -> 2 `done_o` pulses, 8 cycles apart. Vectors with 8 and 0 saturations report 8, then 0.
- Assert `rstn_i` after 4 elements -> all outputs 0 immediately. A new vector then starts at `idx_o` = 0 and `done_o` comes after exactly 8 further elements.
